dm_access_unit: RTL and testbench
=================================

# dm_access_unit

Multi-cycle data-memory responder for the single-issue RISC-V core. It accepts the `dm_write`/`dm_ctrl` access command produced by the control unit, with an address and store data, and performs LB/LH/LW/LBU/LHU and SB/SH/SW. Memory is a byte-wide little-endian RAM accessed one byte per cycle. The unit returns sign- or zero-extended load data with a one-cycle `done` pulse and holds `ready` low while busy.

## Interface
- `DEPTH_BYTES`, default 1024: RAM size in bytes. Must be a power of two.
- `AW`, default 32: address width.

Ports:
- `clk` in 1: single clock. All logic samples on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 1: command valid. Sampled only when `ready`=1.
- `dm_write` in 1: 1 = store, 0 = load.
- `dm_ctrl` in 3: access size, RISC-V funct3 encoding.
- `addr` in AW: byte address.
- `wdata` in 32: store data. The low bytes are used.
- `ready` out 1: unit idle and able to accept a command.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data. Valid while `done`=1, 0 otherwise.
- `err` out 1: illegal command. Valid only with `done`.

## Operation
- `dm_ctrl` encoding:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - 011, 110, 111 are illegal.
  - Stores use only 000/001/010. A store with 100/101 is illegal.
- Byte count N: B/BU = 1, H/HU = 2, W = 4.
- FSM states are IDLE, ACCESS, DONE.
- IDLE:
  - `ready`=1.
  - On `req`=1, latch `dm_write`, `dm_ctrl`, `addr`, `wdata`, and clear the byte counter.
  - Go to ACCESS for a legal command, or to DONE with `err` set for an illegal one.
- ACCESS:
  - Each cycle touches byte i at address (`addr`+i) mod DEPTH_BYTES, so addresses wrap.
  - Store: writes `wdata[8i+7:8i]`.
  - Load: captures the read byte into lane i of an assembly register.
  - After byte N−1, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then return to IDLE.
  - Load result:
    - B/H: sign-extended from bit 7 or bit 15.
    - BU/HU: zero-extended.
    - W: unchanged.
  - Stores and errors drive `rdata`=0.
- `req` while `ready`=0 is ignored. No queueing.
- Upper address bits above log2(DEPTH_BYTES) are ignored.
- Reset clears state to IDLE with outputs `ready`=1, `done`=0, `rdata`=0, `err`=0. RAM contents are not cleared.
- Reset mid-store leaves bytes already written in place and the remaining bytes unchanged.

## Timing
- RAM read is combinational from the byte address register, so one byte completes per cycle.
- Take E0 as the rising edge that accepts `req`:
  - ACCESS occupies edges E1..EN.
  - `done` is high between EN and EN+1.
  - `ready` is high again after EN+1.
- Latency from accept to `done`: B = 2, H = 3, W = 5 cycles. An illegal command takes 1 cycle.
- Back-to-back: the next `req` is accepted at the first edge where `ready`=1, giving a throughput of N+2 cycles per access.
- A load immediately after a store to the same address returns the new data, because the store finishes before `ready` rises.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - An H/HU access with `addr[0]`≠0, or a W access with `addr[1:0]`≠0, is treated as illegal.
  - The unit goes to DONE with `err`=1 after 1 cycle, with no RAM write and `rdata`=0.
- Undefined:
  - Misaligned accesses proceed byte-wise with address wrap.
  - `err` is set only for illegal encodings.

## Structure
- Shared package `dm_pkg`:
  - `dm_ctrl` encoding constants: `DM_B`, `DM_H`, `DM_W`, `DM_BU`, `DM_HU`.
  - State enum `dm_state_t`.
  - Helper function mapping `dm_ctrl` to byte count.
- Sub-module `dm_byte_ram`:
  - DEPTH_BYTES×8 array.
  - Synchronous write, combinational read, no reset.
- `dm_access_unit` contains the FSM, byte counter, assembly register and extension logic.

## Test plan
- SW `0xDEADBEEF` @`0x10`, then LW @`0x10`: `rdata`=`0xDEADBEEF`. `done` arrives 5 cycles after accept for each access.
- After the above, LB @`0x13` gives `0xFFFFFFDE`; LBU @`0x13` gives `0x000000DE`; LH @`0x12` gives `0xFFFFDEAD`; LHU @`0x12` gives `0x0000DEAD`.
- SW `0x11223344` @`0x3FE`:
  - With `DM_ALIGN_CHECK_EN`: `err`=1 after 1 cycle, and LB @`0x3FE` is unchanged.
  - Without it: bytes `0x3FE`=`44`, `0x3FF`=`33`, `0x000`=`22`, `0x001`=`11`, and `err`=0.
- `dm_ctrl`=011, or a store with `dm_ctrl`=100: `done`=1 and `err`=1 in the cycle after accept, `rdata`=0, no RAM change.
- Assert `rst` after the 2nd byte of SW `0xAABBCCDD` @`0x20` over old value 0: `ready`=1 and `done`=0 immediately. LW @`0x20` then returns `0x0000CCDD`.
- `req` pulsed during an ACCESS is ignored: exactly one `done` per accepted command, and RAM is unaffected by the ignored command.

Source files
------------

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access unit:
//   - dm_ctrl access-size encodings (RISC-V funct3 for loads/stores)
//   - FSM state enum
//   - helpers mapping dm_ctrl to a byte count and flagging illegal commands
// -----------------------------------------------------------------------------
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dm_state_t;

  // Number of bytes moved by one access of the given size.
  function automatic logic [2:0] dm_nbytes(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_BU: return 3'd1;
      DM_H, DM_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  // Encoding-level legality: loads accept B/H/W/BU/HU, stores only B/H/W.
  function automatic logic dm_illegal(input logic write, input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_H, DM_W: return 1'b0;
      DM_BU, DM_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// -----------------------------------------------------------------------------
// dm_byte_ram
// DEPTH_BYTES x 8 byte RAM: synchronous write, combinational read.
// Ports:
//   clk       clock
//   i_we      write enable (byte written at rising edge)
//   i_addr    byte address
//   i_wdata   write byte
//   o_rdata   read byte (combinational from i_addr)
// -----------------------------------------------------------------------------
module dm_byte_ram #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_BYTES)-1:0] i_addr,
  input  logic [7:0]                     i_wdata,
  output logic [7:0]                     o_rdata
);

  logic [7:0] r_mem [DEPTH_BYTES];

  // NOTE: storage arrays carry no reset; clearing them would turn the array into
  // thousands of reset flops instead of a RAM, and contents survive reset anyway.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
// Multi-cycle data-memory responder. Executes LB/LH/LW/LBU/LHU and SB/SH/SW
// against a byte-wide little-endian RAM, one byte per cycle, and returns the
// extended load data with a one-cycle done pulse.
//
// Configuration macro: DM_ALIGN_CHECK_EN
//   defined   -> misaligned H/HU/W accesses are rejected with err (no RAM access)
//   undefined -> misaligned accesses proceed byte-wise with address wrap
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             command valid (sampled only while ready=1)
//   dm_write        1 = store, 0 = load
//   dm_ctrl         access size, funct3 encoding
//   addr            byte address (bits above log2(DEPTH_BYTES) ignored)
//   wdata           store data (low N bytes used)
//   ready           idle, able to accept a command
//   done            one-cycle completion pulse
//   rdata           extended load data while done=1, else 0
//   err             illegal command, valid with done
// -----------------------------------------------------------------------------
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          dm_write,
  input  logic [2:0]    dm_ctrl,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err
);

  localparam int LW = $clog2(DEPTH_BYTES);

  dm_state_t     r_state;
  dm_state_t     w_next_state;
  logic          r_write;
  logic [2:0]    r_ctrl;
  logic [LW-1:0] r_baddr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_cnt;
  logic [31:0]   r_asm;
  logic          r_err;

  logic          w_accept;
  logic          w_misalign;
  logic          w_illegal;
  logic [2:0]    w_nbytes;
  logic          w_last;
  logic          w_we;
  logic [7:0]    w_wbyte;
  logic [7:0]    w_rbyte;
  logic [31:0]   w_ext;
  logic          w_unused_addr;

  // Upper address bits select nothing: the RAM aliases across the address space.
  if (AW > LW) begin : g_unused_addr
    assign w_unused_addr = ^addr[AW-1:LW];
  end else begin : g_no_unused_addr
    assign w_unused_addr = 1'b0;
  end

  assign w_accept = (r_state == IDLE) && req;

`ifdef DM_ALIGN_CHECK_EN
  assign w_misalign = (((dm_ctrl == DM_H) || (dm_ctrl == DM_HU)) && addr[0]) ||
                      ((dm_ctrl == DM_W) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_illegal = dm_illegal(dm_write, dm_ctrl) || w_misalign;
  assign w_nbytes  = dm_nbytes(r_ctrl);
  assign w_last    = ({1'b0, r_cnt} == (w_nbytes - 3'd1));
  assign w_we      = (r_state == ACCESS) && r_write;
  assign w_wbyte   = r_wdata[{r_cnt, 3'b000} +: 8];

  dm_byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_baddr),
    .i_wdata (w_wbyte),
    .o_rdata (w_rbyte)
  );

  // NOTE: every state element updates with <= so all flops sample the values
  // from before the edge; blocking assignments here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_ctrl  <= DM_B;
      r_baddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write <= dm_write;
        r_ctrl  <= dm_ctrl;
        r_baddr <= addr[LW-1:0];
        r_wdata <= wdata;
        r_cnt   <= '0;
        r_asm   <= '0;
        r_err   <= w_illegal;
      end else if (r_state == ACCESS) begin
        // Byte address register walks forward and wraps at the RAM size.
        r_baddr <= r_baddr + LW'(1);
        r_cnt   <= r_cnt + 2'd1;
        if (!r_write) r_asm[{r_cnt, 3'b000} +: 8] <= w_rbyte;
      end
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req) w_next_state = w_illegal ? DONE : ACCESS;
      ACCESS:  if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ext = r_asm;
    case (r_ctrl)
      DM_B:    w_ext = {{24{r_asm[7]}}, r_asm[7:0]};
      DM_H:    w_ext = {{16{r_asm[15]}}, r_asm[15:0]};
      DM_BU:   w_ext = {24'h0, r_asm[7:0]};
      DM_HU:   w_ext = {16'h0, r_asm[15:0]};
      default: w_ext = r_asm;
    endcase
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);
  assign err   = done && r_err;
  assign rdata = (done && !r_err && !r_write) ? w_ext : 32'h0;

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
// Directed-vector bench for dm_access_unit. Latency is counted as the number
// of rising edges from the accepting edge up to the edge that consumes done
// (W = 5, H = 3, B = 2, illegal = 1).
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        dm_write;
  logic [2:0]  dm_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_access_unit #(
    .DEPTH_BYTES(1024),
    .AW         (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dm_write (dm_write),
    .dm_ctrl  (dm_ctrl),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .rdata    (rdata),
    .err      (err)
  );

  // Issue one command and wait for its done pulse; returns data, err, latency.
  task automatic run_cmd(input logic w, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic e, output int lat);
    bit got;
    got = 0; rd = 'x; e = 1'bx; lat = -1;
    @(negedge clk);
    req = 1'b1; dm_write = w; dm_ctrl = c; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1; rd = rdata; e = err; lat = k + 1;
      end
      @(posedge clk);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL cmd_timeout addr=%h ctrl=%b: no done within 20 cycles", a, c);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 1'b0; dm_write = 1'b0; dm_ctrl = 3'b000; addr = '0; wdata = '0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_vec++; if (err !== 1'b0)   begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e; int lat;
    run_cmd(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat);
    n_vec++; if (lat !== 5)      begin n_err++; $display("FAIL sw_latency got=%0d exp=5", lat); end
    n_vec++; if (e !== 1'b0)     begin n_err++; $display("FAIL sw_err got=%b exp=0", e); end
    n_vec++; if (rd !== 32'h0)   begin n_err++; $display("FAIL sw_rdata got=%h exp=0", rd); end
    run_cmd(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    n_vec++; if (lat !== 5)      begin n_err++; $display("FAIL lw_latency got=%0d exp=5", lat); end
    n_vec++; if (e !== 1'b0)     begin n_err++; $display("FAIL lw_err got=%b exp=0", e); end
    // Upper address bits alias onto the same RAM bytes.
    run_cmd(1'b0, 3'b010, 32'h0001_0010, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_alias got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic e; int lat;
    run_cmd(1'b0, 3'b000, 32'h13, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hFFFFFFDE) begin n_err++; $display("FAIL lb_data got=%h exp=ffffffde", rd); end
    n_vec++; if (lat !== 2)           begin n_err++; $display("FAIL lb_latency got=%0d exp=2", lat); end
    run_cmd(1'b0, 3'b100, 32'h13, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h000000DE) begin n_err++; $display("FAIL lbu_data got=%h exp=000000de", rd); end
    run_cmd(1'b0, 3'b001, 32'h12, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hFFFFDEAD) begin n_err++; $display("FAIL lh_data got=%h exp=ffffdead", rd); end
    n_vec++; if (lat !== 3)           begin n_err++; $display("FAIL lh_latency got=%0d exp=3", lat); end
    run_cmd(1'b0, 3'b101, 32'h12, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000DEAD) begin n_err++; $display("FAIL lhu_data got=%h exp=0000dead", rd); end
    run_cmd(1'b0, 3'b000, 32'h10, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'hFFFFFFEF) begin n_err++; $display("FAIL lb_low got=%h exp=ffffffef", rd); end
    // SB then LB of a positive byte: no sign extension.
    run_cmd(1'b1, 3'b000, 32'h30, 32'h0000_0071, rd, e, lat);
    run_cmd(1'b0, 3'b000, 32'h30, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h00000071) begin n_err++; $display("FAIL sb_lb got=%h exp=00000071", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic e; int lat;
    logic [7:0] exp_b [4];
    logic [31:0] baddr [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    baddr = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};
`ifdef DM_ALIGN_CHECK_EN
    run_cmd(1'b1, 3'b000, 32'h3FE, 32'h0000_005A, rd, e, lat);
    run_cmd(1'b1, 3'b010, 32'h3FE, 32'h11223344, rd, e, lat);
    n_vec++; if (e !== 1'b1)   begin n_err++; $display("FAIL wrap_align_err got=%b exp=1", e); end
    n_vec++; if (lat !== 1)    begin n_err++; $display("FAIL wrap_align_latency got=%0d exp=1", lat); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL wrap_align_rdata got=%h exp=0", rd); end
    run_cmd(1'b0, 3'b000, 32'h3FE, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000005A) begin n_err++; $display("FAIL wrap_align_unchanged got=%h exp=0000005a", rd); end
`else
    run_cmd(1'b1, 3'b010, 32'h3FE, 32'h11223344, rd, e, lat);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL wrap_sw_err got=%b exp=0", e); end
    n_vec++; if (lat !== 5)  begin n_err++; $display("FAIL wrap_sw_latency got=%0d exp=5", lat); end
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b0, 3'b100, baddr[i], 32'h0, rd, e, lat);
      n_vec++;
      if (rd !== {24'h0, exp_b[i]}) begin
        n_err++; $display("FAIL wrap_byte addr=%h got=%h exp=%h", baddr[i], rd, {24'h0, exp_b[i]});
      end
    end
    run_cmd(1'b0, 3'b010, 32'h3FE, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL wrap_lw got=%h exp=11223344", rd); end
`endif
  endtask

  task automatic test_illegal;
    logic [31:0] rd; logic e; int lat;
    logic [2:0] bad_c [3];
    logic       bad_w [3];
    bad_c = '{3'b011, 3'b100, 3'b110};
    bad_w = '{1'b0, 1'b1, 1'b1};
    run_cmd(1'b1, 3'b010, 32'h40, 32'h01020304, rd, e, lat);
    for (int i = 0; i < 3; i++) begin
      run_cmd(bad_w[i], bad_c[i], 32'h40, 32'hFFFFFFFF, rd, e, lat);
      n_vec++; if (e !== 1'b1)   begin n_err++; $display("FAIL illegal_err ctrl=%b got=%b exp=1", bad_c[i], e); end
      n_vec++; if (lat !== 1)    begin n_err++; $display("FAIL illegal_latency ctrl=%b got=%0d exp=1", bad_c[i], lat); end
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL illegal_rdata ctrl=%b got=%h exp=0", bad_c[i], rd); end
    end
    run_cmd(1'b0, 3'b010, 32'h40, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h01020304) begin n_err++; $display("FAIL illegal_no_write got=%h exp=01020304", rd); end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] rd; logic e; int lat;
    run_cmd(1'b1, 3'b010, 32'h20, 32'h0, rd, e, lat);
    @(negedge clk);
    req = 1'b1; dm_write = 1'b1; dm_ctrl = 3'b010; addr = 32'h20; wdata = 32'hAABBCCDD;
    @(posedge clk);              // E0: accept
    #1 req = 1'b0;
    repeat (2) @(posedge clk);   // E1, E2: bytes 0 and 1 written
    #1 rst = 1'b1;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
    @(negedge clk);
    rst = 1'b0;
    run_cmd(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h0000CCDD) begin n_err++; $display("FAIL midrst_lw got=%h exp=0000ccdd", rd); end
  endtask

  task automatic test_ignored_req;
    logic [31:0] rd; logic e; int lat;
    int n_done;
    logic [31:0] done_data;
    logic ready_low;
    run_cmd(1'b1, 3'b000, 32'h60, 32'h0000_0012, rd, e, lat);
    n_done = 0; done_data = '0; ready_low = 1'b0;
    @(negedge clk);
    req = 1'b1; dm_write = 1'b0; dm_ctrl = 3'b010; addr = 32'h10; wdata = '0;
    @(posedge clk);              // accept LW @0x10
    #1 req = 1'b1; dm_write = 1'b1; dm_ctrl = 3'b000; addr = 32'h60; wdata = 32'h77;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) ready_low = !ready;
      if (k == 2) req = 1'b0;
      if (done) begin n_done++; done_data = rdata; end
    end
    req = 1'b0;
    n_vec++; if (ready_low !== 1'b1) begin n_err++; $display("FAIL busy_ready got_low=%b exp=1", ready_low); end
    n_vec++; if (n_done !== 1)  begin n_err++; $display("FAIL ignored_done_count got=%0d exp=1", n_done); end
    n_vec++; if (done_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL ignored_lw got=%h exp=deadbeef", done_data); end
    run_cmd(1'b0, 3'b100, 32'h60, 32'h0, rd, e, lat);
    n_vec++; if (rd !== 32'h00000012) begin n_err++; $display("FAIL ignored_no_write got=%h exp=00000012", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_wrap();
    test_illegal();
    test_reset_mid_store();
    test_ignored_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
